// File: rtl/stage_writeback_regfile.sv
// MEM/WB pipeline latch, writeback select and 32x32 register file with two
// write-through bypassed read ports for decode.
module stage_writeback_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NREGS    = 32,
    parameter logic [4:0]  LINK_REG = 5'd15,
    parameter logic [4:0]  STAT_REG = 5'd30
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wb_stall,
    input  logic              in_valid,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_pc_plus1,
    input  logic [26:0]       in_target,
    input  logic [4:0]        ctrl_readRegA,
    input  logic [4:0]        ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    output logic              wb_we,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data
);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;

    logic              valid_q,  valid_d;
    logic [4:0]        opcode_q, opcode_d;
    logic [4:0]        rd_q,     rd_d;
    logic [DATA_W-1:0] alu_q,    alu_d;
    logic [DATA_W-1:0] mem_q,    mem_d;
    logic [DATA_W-1:0] pc1_q,    pc1_d;
    logic [26:0]       target_q, target_d;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic wr_class;

    // MEM/WB latch next-state: a stall simply re-selects the held contents.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        valid_d  = valid_q;
        opcode_d = opcode_q;
        rd_d     = rd_q;
        alu_d    = alu_q;
        mem_d    = mem_q;
        pc1_d    = pc1_q;
        target_d = target_q;
        if (!wb_stall) begin
            valid_d  = in_valid;
            opcode_d = in_opcode;
            rd_d     = in_rd;
            alu_d    = in_alu_result;
            mem_d    = in_mem_data;
            pc1_d    = in_pc_plus1;
            target_d = in_target;
        end
    end

    always_comb begin
        wr_class = 1'b0;
        wb_addr  = rd_q;
        wb_data  = alu_q;
        case (opcode_q)
            OP_R, OP_ADDI: wr_class = 1'b1;
            OP_LW: begin
                wr_class = 1'b1;
                wb_data  = mem_q;
            end
            OP_JAL: begin
                wr_class = 1'b1;
                wb_addr  = LINK_REG;
                wb_data  = pc1_q;
            end
            OP_SETX: begin
                wr_class = 1'b1;
                wb_addr  = STAT_REG;
                wb_data  = {{(DATA_W-27){1'b0}}, target_q};
            end
            default: wr_class = 1'b0;
        endcase
        wb_we = valid_q & wr_class & (wb_addr != 5'd0);
    end

    // A held (stalled) instruction rewrites the same value each cycle; harmless.
    always_comb begin
        regs_d = regs_q;
        if (wb_we) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // Read ports: r0 is hard zero, then the in-flight write wins over the array.
    always_comb begin
        data_readRegA = regs_q[ctrl_readRegA];
        if (ctrl_readRegA == 5'd0) begin
            data_readRegA = '0;
        end else if (wb_we && (ctrl_readRegA == wb_addr)) begin
            data_readRegA = wb_data;
        end

        data_readRegB = regs_q[ctrl_readRegB];
        if (ctrl_readRegB == 5'd0) begin
            data_readRegB = '0;
        end else if (wb_we && (ctrl_readRegB == wb_addr)) begin
            data_readRegB = wb_data;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
        if (!reset_n) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            rd_q     <= '0;
            alu_q    <= '0;
            mem_q    <= '0;
            pc1_q    <= '0;
            target_q <= '0;
            // NOTE: the register array is architecturally cleared on reset, so it is built from flops, not RAM.
            regs_q   <= '{default: '0};
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            rd_q     <= rd_d;
            alu_q    <= alu_d;
            mem_q    <= mem_d;
            pc1_q    <= pc1_d;
            target_q <= target_d;
            regs_q   <= regs_d;
        end
    end

endmodule

// File: tb/tb_stage_writeback_regfile.sv
// Scoreboard bench for stage_writeback_regfile: directed scenarios then random
// traffic, checked against an instruction-level register-file model.
module tb_stage_writeback_regfile;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        wb_stall = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_mem_data = '0;
    logic [31:0] in_pc_plus1 = '0;
    logic [26:0] in_target = '0;
    logic [4:0]  ctrl_readRegA = '0;
    logic [4:0]  ctrl_readRegB = '0;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    stage_writeback_regfile dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .wb_stall      (wb_stall),
        .in_valid      (in_valid),
        .in_opcode     (in_opcode),
        .in_rd         (in_rd),
        .in_alu_result (in_alu_result),
        .in_mem_data   (in_mem_data),
        .in_pc_plus1   (in_pc_plus1),
        .in_target     (in_target),
        .ctrl_readRegA (ctrl_readRegA),
        .ctrl_readRegB (ctrl_readRegB),
        .data_readRegA (data_readRegA),
        .data_readRegB (data_readRegB),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        valid;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc1;
        logic [26:0] tgt;
    } insn_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_exp_t;

    int n_checks = 0;
    int n_errors = 0;

    insn_t       m_latch;
    logic [31:0] m_regs [32];
    wb_exp_t     sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic insn_t mk(input logic v, input logic [4:0] op, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic [31:0] mem,
                                 input logic [31:0] pc1, input logic [26:0] tgt);
        insn_t i;
        i.valid = v; i.op = op; i.rd = rd; i.alu = alu; i.mem = mem; i.pc1 = pc1; i.tgt = tgt;
        return i;
    endfunction

    function automatic logic [4:0] m_dest(input insn_t i);
        if (i.op == 5'b00011) return 5'd15;
        if (i.op == 5'b10101) return 5'd30;
        return i.rd;
    endfunction

    function automatic logic [31:0] m_value(input insn_t i);
        if (i.op == 5'b01000) return i.mem;
        if (i.op == 5'b00011) return i.pc1;
        if (i.op == 5'b10101) return {5'b0, i.tgt};
        return i.alu;
    endfunction

    function automatic logic m_writes(input insn_t i);
        logic cls;
        cls = (i.op == 5'b00000) || (i.op == 5'b00101) || (i.op == 5'b01000) ||
              (i.op == 5'b00011) || (i.op == 5'b10101);
        return i.valid && cls && (m_dest(i) != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_writes(m_latch) && m_dest(m_latch) == a) return m_value(m_latch);
        return m_regs[a];
    endfunction

    // One clock of stimulus: drive on the falling edge, check reads just after,
    // then advance the model at the rising edge and queue the expected writeback.
    task automatic step(input insn_t i, input logic stall, input logic rst_n,
                        input logic [4:0] ra, input logic [4:0] rb, input bit chk);
        @(negedge clock);
        reset_n       = rst_n;
        wb_stall      = stall;
        in_valid      = i.valid;
        in_opcode     = i.op;
        in_rd         = i.rd;
        in_alu_result = i.alu;
        in_mem_data   = i.mem;
        in_pc_plus1   = i.pc1;
        in_target     = i.tgt;
        ctrl_readRegA = ra;
        ctrl_readRegB = rb;
        #1;
        if (chk) begin
            check("wb_we", {31'd0, wb_we}, {31'd0, m_writes(m_latch)});
            check($sformatf("readA r%0d", ra), data_readRegA, m_read(ra));
            check($sformatf("readB r%0d", rb), data_readRegB, m_read(rb));
        end
        @(posedge clock);
        if (!rst_n) begin
            m_latch = mk(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 27'd0);
            for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
        end else begin
            if (m_writes(m_latch)) m_regs[m_dest(m_latch)] = m_value(m_latch);
            if (!stall) m_latch = i;
        end
        if (m_writes(m_latch)) sb_q.push_back('{addr: m_dest(m_latch), data: m_value(m_latch)});
    endtask

    // Monitor: every presented writeback must match the next queued expectation.
    always @(negedge clock) begin
        if (wb_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wb_unexpected: got addr %0d data 0x%08h expected no write at %0t",
                         wb_addr, wb_data, $time);
            end else begin
                wb_exp_t e;
                e = sb_q.pop_front();
                check("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
                check("wb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        insn_t idle;
        insn_t ri;
        logic [4:0] ops [10];
        logic [4:0] ra, rb;
        ops = '{5'b00000, 5'b00101, 5'b01000, 5'b00011, 5'b10101,
                5'b00111, 5'b00010, 5'b00001, 5'b11111, 5'b00100};
        idle = mk(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 27'd0);
        m_latch = idle;
        for (int r = 0; r < 32; r++) m_regs[r] = 32'hDEAD_BEEF;

        // Reset for two cycles, then every register reads zero.
        step(idle, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        step(idle, 1'b0, 1'b0, 5'd1, 5'd2, 1'b1);
        for (int a = 1; a < 32; a++) step(idle, 1'b0, 1'b1, 5'(a), 5'(32 - a), 1'b1);

        // addi r3 = 0xAA: bypass during the writeback cycle, then from the array.
        step(mk(1'b1, 5'b00101, 5'd3, 32'h0000_00AA, 32'd0, 32'd0, 27'd0), 1'b0, 1'b1, 5'd3, 5'd3, 1'b1);
        step(idle, 1'b0, 1'b1, 5'd3, 5'd3, 1'b1);
        step(idle, 1'b0, 1'b1, 5'd3, 5'd0, 1'b1);

        // jal -> r15, setx -> r30 (rd field deliberately unrelated).
        step(mk(1'b1, 5'b00011, 5'd9, 32'h1111_1111, 32'd0, 32'h0000_0040, 27'd0), 1'b0, 1'b1, 5'd15, 5'd30, 1'b1);
        step(mk(1'b1, 5'b10101, 5'd9, 32'h2222_2222, 32'd0, 32'd0, 27'h123), 1'b0, 1'b1, 5'd15, 5'd30, 1'b1);
        step(idle, 1'b0, 1'b1, 5'd30, 5'd15, 1'b1);
        step(idle, 1'b0, 1'b1, 5'd15, 5'd30, 1'b1);

        // R-type to r0 is suppressed.
        step(mk(1'b1, 5'b00000, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 27'd0), 1'b0, 1'b1, 5'd0, 5'd0, 1'b1);
        step(idle, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1);

        // r5 = 0x1234, then sw/bne targeting r5 must leave it unchanged.
        step(mk(1'b1, 5'b00101, 5'd5, 32'h0000_1234, 32'd0, 32'd0, 27'd0), 1'b0, 1'b1, 5'd5, 5'd0, 1'b1);
        step(mk(1'b1, 5'b00111, 5'd5, 32'h5555_5555, 32'd0, 32'd0, 27'd0), 1'b0, 1'b1, 5'd5, 5'd5, 1'b1);
        step(mk(1'b1, 5'b00010, 5'd5, 32'h6666_6666, 32'd0, 32'd0, 27'd0), 1'b0, 1'b1, 5'd5, 5'd5, 1'b1);
        step(idle, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1);
        step(idle, 1'b0, 1'b1, 5'd5, 5'd3, 1'b1);

        // Stall holds addi r7 while an lw r8 waits; reset mid-stall clears everything.
        step(mk(1'b1, 5'b00101, 5'd7, 32'h0000_0077, 32'd0, 32'd0, 27'd0), 1'b0, 1'b1, 5'd7, 5'd8, 1'b1);
        for (int k = 0; k < 3; k++)
            step(mk(1'b1, 5'b01000, 5'd8, 32'd0, 32'hCAFE_0008, 32'd0, 27'd0), 1'b1, 1'b1, 5'd7, 5'd8, 1'b1);
        step(mk(1'b1, 5'b01000, 5'd8, 32'd0, 32'hCAFE_0008, 32'd0, 27'd0), 1'b1, 1'b0, 5'd7, 5'd8, 1'b1);
        step(idle, 1'b0, 1'b1, 5'd7, 5'd3, 1'b1);
        step(idle, 1'b0, 1'b1, 5'd15, 5'd30, 1'b1);

        // Random traffic with stalls, occasional resets and reads biased toward the pending write.
        for (int n = 0; n < 400; n++) begin
            ri = mk($urandom_range(0, 9) != 0, ops[$urandom_range(0, 9)], 5'($urandom_range(0, 31)),
                    $urandom, $urandom, $urandom, 27'($urandom));
            ra = ($urandom_range(0, 1) == 1) ? m_dest(m_latch) : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 2) == 0) ? m_dest(m_latch) : 5'($urandom_range(0, 31));
            step(ri, $urandom_range(0, 4) == 0, $urandom_range(0, 49) != 0, ra, rb, 1'b1);
        end

        for (int k = 0; k < 3; k++) step(idle, 1'b0, 1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1);
        @(negedge clock);
        #2;
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
